// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: control bit positions,
// mode encodings and FSM state encoding.
package alu_seq_pkg;

   localparam int EX = 5;
   localparam int NX = 4;
   localparam int EY = 3;
   localparam int NY = 2;
   localparam int F  = 1;
   localparam int NO = 0;

   localparam logic [1:0] MODE_ALU = 2'b00;
   localparam logic [1:0] MODE_SHL = 2'b01;
   localparam logic [1:0] MODE_SHR = 2'b10;
   localparam logic [1:0] MODE_MUL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Command/result bundle of the sequential ALU; master issues commands
// and consumes results, slave is the ALU side.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [5:0]       c;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             z_flag;
   logic             n_flag;
   logic             c_flag;

   modport master (
      output in_valid, x, y, c, mode, out_ready,
      input  in_ready, out_valid, out, z_flag, n_flag, c_flag
   );

   modport slave (
      input  in_valid, x, y, c, mode, out_ready,
      output in_ready, out_valid, out, z_flag, n_flag, c_flag
   );
endinterface

// File: rtl/alu_seq_alu_core.sv
// Combinational two-operand ALU with operand zero/invert controls
// and optional output inversion.
module alu_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       c,
   output logic [WIDTH-1:0] r,
   output logic             carry
);

   logic [WIDTH-1:0] w_xi;
   logic [WIDTH-1:0] w_yi;
   logic [WIDTH:0]   w_sum;

   always_comb begin
      w_xi = c[EX] ? x : '0;
      if (c[NX]) w_xi = ~w_xi;
      w_yi = c[EY] ? y : '0;
      if (c[NY]) w_yi = ~w_yi;
      w_sum = {1'b0, w_xi} + {1'b0, w_yi};
      r = c[F] ? w_sum[WIDTH-1:0] : (w_xi & w_yi);
      if (c[NO]) r = ~r;
      carry = c[F] & w_sum[WIDTH];
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ALU op, bit-serial shifts and
// shift-and-add multiply behind a valid/ready command/result handshake.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       c,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             z_flag,
   output logic             n_flag,
   output logic             c_flag
);

   localparam int AW = $clog2(WIDTH);
   localparam int CW = AW + 1;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mx;
   logic [WIDTH-1:0] r_my;
   logic [WIDTH-1:0] r_out;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_mode;
   logic             r_z;
   logic             r_n;
   logic             r_c;

   logic [WIDTH-1:0] w_alu_r;
   logic             w_alu_c;
   logic [AW-1:0]    w_amt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_last;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .x     (x),
      .y     (y),
      .c     (c),
      .r     (w_alu_r),
      .carry (w_alu_c)
   );

   assign w_amt  = y[AW-1:0];
   assign w_last = (r_cnt == CW'(1));

   always_comb begin
      w_acc_nxt = r_acc;
      case (r_mode)
         MODE_SHL: w_acc_nxt = r_acc << 1;
         MODE_SHR: w_acc_nxt = r_acc >> 1;
         MODE_MUL: w_acc_nxt = r_my[0] ? r_acc + r_mx : r_acc;
         default:  w_acc_nxt = r_acc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               if (mode == MODE_ALU)
                  w_next = S_DONE;
               else if (mode != MODE_MUL && w_amt == '0)
                  w_next = S_DONE;
               else
                  w_next = S_RUN;
            end
         end
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc  <= '0;
         r_mx   <= '0;
         r_my   <= '0;
         r_out  <= '0;
         r_cnt  <= '0;
         r_mode <= MODE_ALU;
         r_z    <= 1'b0;
         r_n    <= 1'b0;
         r_c    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mode <= mode;
                  r_cnt  <= '0;
                  if (mode == MODE_ALU) begin
                     r_out <= w_alu_r;
                     r_z   <= (w_alu_r == '0);
                     r_n   <= w_alu_r[WIDTH-1];
                     r_c   <= w_alu_c;
                  end else if (mode == MODE_MUL) begin
                     r_acc <= '0;
                     r_mx  <= x;
                     r_my  <= y;
                     r_cnt <= CW'(WIDTH);
                  end else begin
                     r_acc <= x;
                     r_cnt <= CW'(w_amt);
                     // zero shift amount finishes in the accept cycle
                     if (w_amt == '0) begin
                        r_out <= x;
                        r_z   <= (x == '0);
                        r_n   <= x[WIDTH-1];
                        r_c   <= 1'b0;
                     end
                  end
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_mx  <= r_mx << 1;
               r_my  <= r_my >> 1;
               r_cnt <= r_cnt - CW'(1);
               if (w_last) begin
                  r_out <= w_acc_nxt;
                  r_z   <= (w_acc_nxt == '0);
                  r_n   <= w_acc_nxt[WIDTH-1];
                  r_c   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out       = r_out;
   assign z_flag    = r_z;
   assign n_flag    = r_n;
   assign c_flag    = r_c;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=16 and WIDTH=8 against an
// arithmetic reference model.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(16)) a ();
   alu_seq_if #(.WIDTH(8))  b ();

   alu_seq #(.WIDTH(16)) d16 (
      .clk(clk), .rst(rst),
      .in_valid(a.in_valid), .in_ready(a.in_ready),
      .x(a.x), .y(a.y), .c(a.c), .mode(a.mode),
      .out_valid(a.out_valid), .out_ready(a.out_ready),
      .out(a.out), .z_flag(a.z_flag), .n_flag(a.n_flag), .c_flag(a.c_flag)
   );

   alu_seq #(.WIDTH(8)) d8 (
      .clk(clk), .rst(rst),
      .in_valid(b.in_valid), .in_ready(b.in_ready),
      .x(b.x), .y(b.y), .c(b.c), .mode(b.mode),
      .out_valid(b.out_valid), .out_ready(b.out_ready),
      .out(b.out), .z_flag(b.z_flag), .n_flag(b.n_flag), .c_flag(b.c_flag)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the operations as plain arithmetic on w-bit words
   function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic [5:0] c, input logic [1:0] m,
                                 output logic [63:0] r, output logic z, output logic n,
                                 output logic cf, output int lat);
      logic [63:0] mask, xi, yi, sum;
      int amt;
      mask = (64'd1 << w) - 1;
      amt = int'(y % 64'(w));
      cf = 1'b0;
      case (m)
         2'b00: begin
            xi = c[5] ? (x & mask) : 64'd0;
            if (c[4]) xi = ~xi & mask;
            yi = c[3] ? (y & mask) : 64'd0;
            if (c[2]) yi = ~yi & mask;
            sum = xi + yi;
            r = c[1] ? (sum & mask) : (xi & yi);
            if (c[0]) r = ~r & mask;
            cf = c[1] & sum[w];
            lat = 1;
         end
         2'b01: begin r = (x << amt) & mask; lat = amt + 1; end
         2'b10: begin r = (x & mask) >> amt; lat = amt + 1; end
         default: begin r = (x * y) & mask; lat = w + 1; end
      endcase
      z = (r == 64'd0);
      n = r[w-1];
   endfunction

   task automatic samp(input bit w8, output logic [63:0] o, output logic ov,
                       output logic ir, output logic z, output logic n, output logic cf);
      if (w8) begin
         o = {56'd0, b.out}; ov = b.out_valid; ir = b.in_ready;
         z = b.z_flag; n = b.n_flag; cf = b.c_flag;
      end else begin
         o = {48'd0, a.out}; ov = a.out_valid; ir = a.in_ready;
         z = a.z_flag; n = a.n_flag; cf = a.c_flag;
      end
   endtask

   task automatic drive(input bit w8, input logic v, input logic [63:0] x,
                        input logic [63:0] y, input logic [5:0] c, input logic [1:0] m);
      if (w8) begin
         b.in_valid = v; b.x = x[7:0]; b.y = y[7:0]; b.c = c; b.mode = m;
      end else begin
         a.in_valid = v; a.x = x[15:0]; a.y = y[15:0]; a.c = c; a.mode = m;
      end
   endtask

   task automatic set_ready(input bit w8, input logic r);
      if (w8) b.out_ready = r;
      else    a.out_ready = r;
   endtask

   // Issue one command; inputs are scrambled right after the accept edge
   task automatic start(input bit w8, input logic [63:0] x, input logic [63:0] y,
                        input logic [5:0] c, input logic [1:0] m);
      logic [63:0] o; logic ov, ir, z, n, cf;
      @(negedge clk);
      drive(w8, 1'b1, x, y, c, m);
      samp(w8, o, ov, ir, z, n, cf);
      chk("in_ready_before_accept", ir, 1'b1);
      @(posedge clk);
      #1;
      drive(w8, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
            6'($urandom), 2'($urandom));
   endtask

   task automatic wait_done(input bit w8, output int lat);
      logic [63:0] o; logic ov, ir, z, n, cf;
      lat = 1;
      samp(w8, o, ov, ir, z, n, cf);
      while (!ov && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         samp(w8, o, ov, ir, z, n, cf);
      end
      if (!ov) chk("result_timeout", ov, 1'b1);
   endtask

   task automatic consume(input bit w8);
      logic [63:0] o; logic ov, ir, z, n, cf;
      set_ready(w8, 1'b1);
      @(posedge clk);
      #1;
      set_ready(w8, 1'b0);
      samp(w8, o, ov, ir, z, n, cf);
      chk("idle_after_consume_valid", ov, 1'b0);
      chk("idle_after_consume_ready", ir, 1'b1);
   endtask

   task automatic full(input string tag, input bit w8, input logic [63:0] x,
                       input logic [63:0] y, input logic [5:0] c, input logic [1:0] m);
      logic [63:0] o, er; logic ov, ir, z, n, cf, ez, en, ec;
      int lat, elat;
      model(w8 ? 8 : 16, x, y, c, m, er, ez, en, ec, elat);
      start(w8, x, y, c, m);
      wait_done(w8, lat);
      samp(w8, o, ov, ir, z, n, cf);
      chk({tag, "_out"}, o, er);
      chk({tag, "_z"}, z, ez);
      chk({tag, "_n"}, n, en);
      chk({tag, "_c"}, cf, ec);
      chk({tag, "_latency"}, 64'(lat), 64'(elat));
      consume(w8);
   endtask

   function automatic logic [15:0] named(input int k, input logic [15:0] x, input logic [15:0] y);
      case (k)
         0: return x + y;   1: return x - y;    2: return y - x;
         3: return x & y;   4: return x | y;    5: return 16'd0;
         6: return 16'd1;   7: return 16'hFFFF; 8: return x;
         9: return y;       10: return ~x;      11: return ~y;
         12: return -x;     13: return -y;      14: return x + 16'd1;
         15: return y + 16'd1; 16: return x - 16'd1;
         default: return y - 16'd1;
      endcase
   endfunction

   logic [5:0] codes [18] = '{
      6'b101010, 6'b111011, 6'b101111, 6'b101000, 6'b111101, 6'b000010,
      6'b010111, 6'b010010, 6'b100100, 6'b011000, 6'b100101, 6'b011001,
      6'b100111, 6'b011011, 6'b110111, 6'b011111, 6'b100110, 6'b011010
   };
   logic [15:0] grid [5] = '{16'h0000, 16'h0001, 16'h1234, 16'h8000, 16'hFFFF};

   initial begin
      logic [63:0] o, hold_o;
      logic ov, ir, z, n, cf, seen;
      int lat;

      drive(1'b0, 1'b0, 0, 0, 6'd0, 2'd0);
      drive(1'b1, 1'b0, 0, 0, 6'd0, 2'd0);
      set_ready(1'b0, 1'b0);
      set_ready(1'b1, 1'b0);

      #1 rst = 1'b1;
      #1;
      samp(1'b0, o, ov, ir, z, n, cf);
      chk("rst_out", o, 0);
      chk("rst_valid", ov, 0);
      chk("rst_in_ready", ir, 1);
      chk("rst_flags", {z, n, cf}, 3'b000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      full("alu_add", 1'b0, 64'h1234, 64'h0FFF, 6'b101010, MODE_ALU);
      full("alu_wrap", 1'b0, 64'hFFFF, 64'h0001, 6'b101010, MODE_ALU);
      full("alu_sub", 1'b0, 64'h0003, 64'h0005, 6'b111011, MODE_ALU);
      full("shl5", 1'b0, 64'h0001, 64'hFFF5, 6'b000000, MODE_SHL);
      full("shr0", 1'b0, 64'hABCD, 64'h0000, 6'b000000, MODE_SHR);
      full("shr9", 1'b0, 64'h8F00, 64'h0009, 6'b000000, MODE_SHR);
      full("mul16", 1'b0, 64'd300, 64'd300, 6'b000000, MODE_MUL);
      full("mul8", 1'b1, 64'h0F, 64'h11, 6'b000000, MODE_MUL);
      full("shl8", 1'b1, 64'h81, 64'hF3, 6'b000000, MODE_SHL);

      // result held while the consumer stalls
      start(1'b0, 64'h8001, 64'h0000, 6'b100100, MODE_ALU);
      wait_done(1'b0, lat);
      samp(1'b0, hold_o, ov, ir, z, n, cf);
      chk("hold_initial", hold_o, 64'h8001);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         samp(1'b0, o, ov, ir, z, n, cf);
         chk("hold_out", o, hold_o);
         chk("hold_state", {ov, ir, z, n, cf}, 5'b10010);
      end
      consume(1'b0);

      // reset in the middle of a multiply
      start(1'b0, 64'd1234, 64'd567, 6'b000000, MODE_MUL);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      samp(1'b0, o, ov, ir, z, n, cf);
      chk("midrst_valid", ov, 0);
      chk("midrst_out", o, 0);
      chk("midrst_idle", ir, 1);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         samp(1'b0, o, ov, ir, z, n, cf);
         seen = seen | ov;
      end
      chk("midrst_no_result", seen, 0);
      full("post_rst_alu", 1'b0, 64'h0F0F, 64'h00FF, 6'b111101, MODE_ALU);

      // named ALU functions over a grid of operands
      for (int xi = 0; xi < 5; xi++) begin
         for (int yi = 0; yi < 5; yi++) begin
            for (int k = 0; k < 18; k++) begin
               start(1'b0, 64'(grid[xi]), 64'(grid[yi]), codes[k], MODE_ALU);
               wait_done(1'b0, lat);
               samp(1'b0, o, ov, ir, z, n, cf);
               chk($sformatf("named%0d_x%0h_y%0h", k, grid[xi], grid[yi]),
                   o, 64'(named(k, grid[xi], grid[yi])));
               set_ready(1'b0, 1'b1);
               @(posedge clk);
               #1;
               set_ready(1'b0, 1'b0);
            end
         end
      end

      for (int i = 0; i < 40; i++)
         full($sformatf("rand16_%0d", i), 1'b0, 64'($urandom), 64'($urandom),
              6'($urandom), 2'($urandom));
      for (int i = 0; i < 20; i++)
         full($sformatf("rand8_%0d", i), 1'b1, 64'($urandom), 64'($urandom),
              6'($urandom), 2'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values are powers of two from 4 to 64.
REQ-002 SHALL have ports, in order:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/command valid.
- in_ready  output  1  block can accept a command.
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y, also the shift amount.
- c  input  6  control bits: ex=bit5, nx=bit4, ey=bit3, ny=bit2, f=bit1, no=bit0.
- mode  input  2  operation mode: 00 ALU, 01 SHL, 10 SHR, 11 MUL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- z_flag  output  1  out equals zero.
- n_flag  output  1  out[WIDTH-1].
- c_flag  output  1  carry out of the ALU adder.

Function
REQ-003 SHALL implement ALU mode as follows:
- xi = ex ? x : 0, then inverted if nx.
- yi = ey ? y : 0, then inverted if ny.
- r = f ? xi+yi (mod 2^WIDTH) : xi&yi, then inverted if no.
REQ-004 SHALL set c_flag to the carry out of bit WIDTH-1 of xi+yi when mode=00 and f=1, and to 0 otherwise.
REQ-005 SHALL compute SHL as a logical left shift of x and SHR as a logical right shift of x, using amount = y[clog2(WIDTH)-1:0] and ignoring the other bits of y.
REQ-006 SHALL compute MUL as the low WIDTH bits of x*y (unsigned), by shift-and-add.
REQ-007 SHALL use a state machine with states IDLE, RUN and DONE; the reset state is IDLE.
REQ-008 SHALL drive in_ready=1 in IDLE only; a command is accepted on an edge where in_valid & in_ready.
REQ-009 SHALL capture x, y, c and mode on acceptance; later input changes do not affect the result.
REQ-010 SHALL handle ALU mode by registering the result at the accept edge and going IDLE->DONE; out_valid rises 1 cycle after accept.
REQ-011 SHALL handle SHL/SHR by going IDLE->RUN and shifting 1 bit per cycle for amount cycles, then RUN->DONE; out_valid rises amount+1 cycles after accept.
REQ-012 SHALL treat amount=0 as RUN for 0 cycles: the block goes directly to DONE, out_valid rises 1 cycle after accept, and out=x.
REQ-013 SHALL handle MUL by processing 1 multiplier bit per cycle in RUN for WIDTH cycles; out_valid rises WIDTH+1 cycles after accept.
REQ-014 SHALL drive out_valid=1 only in DONE, holding out and all flags stable until out_valid & out_ready, then go DONE->IDLE.
REQ-015 SHALL NOT accept a new command in the cycle a result is consumed; the minimum issue interval is 2 cycles for ALU mode.
REQ-016 SHALL update z_flag and n_flag together with out, derived from the registered result.
REQ-017 SHALL hold out, flags and the state while out_ready=0 in DONE, with no bound on the hold time.

Reset
REQ-018 SHALL, while rst=1 (asynchronously), force state=IDLE, out=0, out_valid=0, z_flag=0, n_flag=0, c_flag=0, and clear the internal counters; in_ready=1 once the state is IDLE.
REQ-019 SHALL discard any in-progress RUN or DONE operation when rst is asserted, producing no result after reset.

Structure
REQ-020 SHALL take the following constants from shared package alu_seq_pkg: control bit positions (EX, NX, EY, NY, F, NO), mode encodings (MODE_ALU, MODE_SHL, MODE_SHR, MODE_MUL) and state encodings.
REQ-021 SHALL place the combinational ALU function (REQ-003, REQ-004) in sub-module alu_core, parameterised by WIDTH, with outputs r and carry.
REQ-022 SHALL use a counter of width clog2(WIDTH)+1 for the RUN cycles.

Verification
REQ-023 The bench SHALL cover these directed scenarios (WIDTH=16 unless stated):
- ALU, x=0x1234, y=0x0FFF, c=0b101010 (ex+ey+f) -> out=0x2233, c_flag=0, out_valid exactly 1 cycle after accept.
- ALU, x=0xFFFF, y=0x0001, c=0b101010 -> out=0x0000, z_flag=1, c_flag=1; then x=0x0003, y=0x0005, c=0b111011 (X-Y) -> out=0xFFFE, n_flag=1.
- SHL, x=0x0001, y=0xFFF5 (amount 5) -> out=0x0020 after 6 cycles; SHR, y=0 -> out=x after 1 cycle.
- MUL, x=300, y=300 -> out=0x5F90 (90000 mod 65536) after 17 cycles; repeat with WIDTH=8, x=0x0F, y=0x11 -> out=0xFF after 9 cycles.
- out_ready held 0 for 10 cycles in DONE -> out and flags stable, in_ready=0 throughout; on release, in_ready=1 the following cycle.
- rst asserted mid-MUL (cycle 5) -> out_valid=0 and out=0 immediately, state IDLE, no result after rst deasserts; a fresh ALU command then completes normally.
REQ-024 The bench SHALL also replay all 18 control/result pairs from the existing 16-bit ALU test (X+Y, X-Y, Y-X, X&Y, X|Y, 0, 1, -1, X, Y, !X, !Y, -X, -Y, X+1, Y+1, X-1, Y-1) in ALU mode over a swept grid of x and y values, checking each result at out.
